// File: rtl/mf_pll_lock_supervisor_pkg.sv
// Purpose : shared state encoding and width helpers for the PLL lock supervisor.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
package mf_pll_lock_supervisor_pkg;

    // Encoding is fixed because it is exported on state_dbg.
    typedef enum logic [2:0] {
        ST_PULSE   = 3'd0,
        ST_WAIT    = 3'd1,
        ST_STABLE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_FAIL    = 3'd5
    } pllsup_state_t;

    // Counter width for a given limit; never returns 0 so a limit of 1
    // still yields a legal one-bit counter.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mf_sync2.sv
// Purpose : generic 2-flop synchroniser for asynchronous level inputs.
// Latency : 2 clk_i cycles from d_i to q_o.
// Backpressure: none; level signal, no handshake.
// Ports   : clk_i sampling clock, rst_n_i synchronous active-low reset,
//           d_i asynchronous input, q_o synchronised output.
module mf_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mf_pll_lock_supervisor.sv
// Purpose : drives PLL reset, debounces lock, retries on timeout, stages domain resets.
// Latency : pll_locked reaches the FSM after 2 syncs; outputs are registered (+1 cycle).
// Backpressure: none; free-running supervisor, retry is a single-cycle request honoured only in FAIL.
// Ports   : refclk/rst_n clock and sync active-low reset; pll_locked async lock flag;
//           retry restart pulse; pll_rst PLL reset; ch_rst_n staged domain resets;
//           all_ready/fail status; loss_count saturating loss counter; state_dbg FSM state.
module mf_pll_lock_supervisor
    import mf_pll_lock_supervisor_pkg::*;
#(
    parameter int NUM_CH       = 5,
    parameter int RST_PULSE    = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int STAGE_GAP    = 64,
    parameter int MAX_RETRY    = 7,
    parameter int CNT_W        = 8
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              retry,
    output logic              pll_rst,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              all_ready,
    output logic              fail,
    output logic [CNT_W-1:0]  loss_count,
    output logic [2:0]        state_dbg
);

    // One phase timer serves every timed state, so it is sized for the
    // largest of the limits it has to reach.
    localparam int TMR_LIMIT = max_int(max_int(RST_PULSE, LOCK_TIMEOUT),
                                       max_int(LOCK_STABLE, STAGE_GAP));
    localparam int TMR_W     = clog2_min1(TMR_LIMIT);
    localparam int RTY_W     = clog2_min1(MAX_RETRY + 1);

    localparam logic [TMR_W-1:0]  PULSE_LAST   = TMR_W'(RST_PULSE - 1);
    localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  STABLE_LAST  = TMR_W'(LOCK_STABLE - 1);
    localparam logic [TMR_W-1:0]  GAP_LAST     = TMR_W'(STAGE_GAP - 1);
    localparam logic [RTY_W-1:0]  RETRY_LIMIT  = RTY_W'(MAX_RETRY);
    localparam logic [NUM_CH-1:0] CH_FIRST     = NUM_CH'(1);

    pllsup_state_t     state_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [RTY_W-1:0]  retry_cnt_q;
    logic              pll_rst_q;
    logic [NUM_CH-1:0] ch_rst_n_q;
    logic              all_ready_q;
    logic              fail_q;
    logic [CNT_W-1:0]  loss_count_q;

    logic              lk;
    logic              loss_d;
    logic [RTY_W-1:0]  retry_inc_d;
    logic [CNT_W-1:0]  loss_sat_d;
    logic [NUM_CH-1:0] ch_shift_d;

    mf_sync2 #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk_i  (refclk),
        .rst_n_i(rst_n),
        .d_i    (pll_locked),
        .q_o    (lk)
    );

    // Lock loss only matters once domains have started coming out of reset.
    assign loss_d      = !lk && ((state_q == ST_RELEASE) || (state_q == ST_RUN));
    assign retry_inc_d = retry_cnt_q + 1'b1;
    assign loss_sat_d  = (&loss_count_q) ? loss_count_q : loss_count_q + 1'b1;
    // Shift in a one from the bottom so bit 0 is always the first released.
    assign ch_shift_d  = (ch_rst_n_q << 1) | CH_FIRST;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q      <= ST_PULSE;
            tmr_q        <= '0;
            retry_cnt_q  <= '0;
            pll_rst_q    <= 1'b1;
            ch_rst_n_q   <= '0;
            all_ready_q  <= 1'b0;
            fail_q       <= 1'b0;
            loss_count_q <= '0;
        end else if (loss_d) begin
            // Drop every domain at once and restart the PLL; this is not
            // a failed attempt, so the retry budget is left alone.
            state_q      <= ST_PULSE;
            tmr_q        <= '0;
            pll_rst_q    <= 1'b1;
            ch_rst_n_q   <= '0;
            all_ready_q  <= 1'b0;
            loss_count_q <= loss_sat_d;
        end else begin
            case (state_q)
                ST_PULSE: begin
                    if (tmr_q == PULSE_LAST) begin
                        state_q   <= ST_WAIT;
                        tmr_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lk) begin
                        state_q <= ST_STABLE;
                        tmr_q   <= '0;
                    end else if (tmr_q == TIMEOUT_LAST) begin
                        tmr_q       <= '0;
                        retry_cnt_q <= retry_inc_d;
                        pll_rst_q   <= 1'b1;
                        if (retry_inc_d == RETRY_LIMIT) begin
                            state_q <= ST_FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= ST_PULSE;
                        end
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    // A drop on the final counting cycle still goes back to WAIT.
                    if (!lk) begin
                        state_q <= ST_WAIT;
                        tmr_q   <= '0;
                    end else if (tmr_q == STABLE_LAST) begin
                        state_q     <= ST_RELEASE;
                        tmr_q       <= '0;
                        retry_cnt_q <= '0;
                        ch_rst_n_q  <= CH_FIRST;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (ch_rst_n_q[NUM_CH-1]) begin
                        state_q     <= ST_RUN;
                        all_ready_q <= 1'b1;
                    end else if (tmr_q == GAP_LAST) begin
                        tmr_q      <= '0;
                        ch_rst_n_q <= ch_shift_d;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    all_ready_q <= 1'b1;
                end
                ST_FAIL: begin
                    if (retry) begin
                        state_q     <= ST_PULSE;
                        tmr_q       <= '0;
                        retry_cnt_q <= '0;
                        fail_q      <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encodings recover through a fresh PLL reset.
                    state_q     <= ST_PULSE;
                    tmr_q       <= '0;
                    pll_rst_q   <= 1'b1;
                    ch_rst_n_q  <= '0;
                    all_ready_q <= 1'b0;
                    fail_q      <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst    = pll_rst_q;
    assign ch_rst_n   = ch_rst_n_q;
    assign all_ready  = all_ready_q;
    assign fail       = fail_q;
    assign loss_count = loss_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mf_pll_lock_supervisor.sv
// Purpose : directed self-checking bench for mf_pll_lock_supervisor.
// Latency : expected values are hand-computed per cycle after reset release.
// Backpressure: n/a.
module tb_mf_pll_lock_supervisor;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       retry;
    logic       pll_rst;
    logic [2:0] ch_rst_n;
    logic       all_ready;
    logic       fail;
    logic [1:0] loss_count;
    logic [2:0] state_dbg;

    int checks;
    int errors;

    logic [2:0] exp_state;
    logic [2:0] exp_ch;
    logic       exp_pr;
    logic       exp_ar;

    mf_pll_lock_supervisor #(
        .NUM_CH      (3),
        .RST_PULSE   (4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(32),
        .STAGE_GAP   (2),
        .MAX_RETRY   (3),
        .CNT_W       (2)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .retry     (retry),
        .pll_rst   (pll_rst),
        .ch_rst_n  (ch_rst_n),
        .all_ready (all_ready),
        .fail      (fail),
        .loss_count(loss_count),
        .state_dbg (state_dbg)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset(input logic lock_lvl);
        @(negedge refclk);
        rst_n      = 1'b0;
        pll_locked = lock_lvl;
        retry      = 1'b0;
        repeat (2) @(negedge refclk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge refclk);
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        retry      = 1'b0;
        repeat (2) @(negedge refclk);
        checks++;
        if (pll_rst !== 1'b1 || ch_rst_n !== 3'b000 || all_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs pll_rst=%b ch=%b ar=%b (want 1 000 0)", pll_rst, ch_rst_n, all_ready);
        end
        checks++;
        if (fail !== 1'b0 || loss_count !== 2'd0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_status fail=%b loss=%0d state=%0d (want 0 0 0)", fail, loss_count, state_dbg);
        end
    endtask

    task automatic test_clean_lock;
        do_reset(1'b1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge refclk);
            exp_state = (k <= 3) ? 3'd0 : (k == 4) ? 3'd1 : (k <= 12) ? 3'd2 : (k <= 17) ? 3'd3 : 3'd4;
            exp_ch    = (k < 13) ? 3'b000 : (k < 15) ? 3'b001 : (k < 17) ? 3'b011 : 3'b111;
            exp_pr    = (k <= 3);
            exp_ar    = (k >= 18);
            checks++;
            if (state_dbg !== exp_state || ch_rst_n !== exp_ch || pll_rst !== exp_pr || all_ready !== exp_ar) begin
                errors++;
                $display("FAIL clean_lock k=%0d state=%0d/%0d ch=%b/%b pll_rst=%b/%b ar=%b/%b",
                         k, state_dbg, exp_state, ch_rst_n, exp_ch, pll_rst, exp_pr, all_ready, exp_ar);
            end
        end
    endtask

    task automatic test_glitch;
        do_reset(1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge refclk);
            if (k == 10) begin
                checks++;
                if (state_dbg !== 3'd2) begin
                    errors++;
                    $display("FAIL glitch_pre k=%0d state=%0d want 2", k, state_dbg);
                end
            end
            if (k == 11) begin
                checks++;
                if (state_dbg !== 3'd1) begin
                    errors++;
                    $display("FAIL glitch_wait k=%0d state=%0d want 1", k, state_dbg);
                end
            end
            if (k >= 12 && k <= 19) begin
                checks++;
                if (state_dbg !== 3'd2 || ch_rst_n !== 3'b000) begin
                    errors++;
                    $display("FAIL glitch_recount k=%0d state=%0d ch=%b want 2 000", k, state_dbg, ch_rst_n);
                end
            end
            if (k == 20) begin
                checks++;
                if (state_dbg !== 3'd3 || ch_rst_n !== 3'b001 || loss_count !== 2'd0) begin
                    errors++;
                    $display("FAIL glitch_release state=%0d ch=%b loss=%0d want 3 001 0", state_dbg, ch_rst_n, loss_count);
                end
            end
            // One-cycle drop lands on the FSM when the stable count is 5.
            if (k == 8) pll_locked = 1'b0;
            if (k == 9) pll_locked = 1'b1;
        end
    endtask

    task automatic test_timeout;
        do_reset(1'b0);
        for (int k = 1; k <= 220; k++) begin
            @(negedge refclk);
            if (k == 3 || k == 36 || k == 111) begin
                checks++;
                if (state_dbg !== 3'd0 || pll_rst !== 1'b1 || fail !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_pulse k=%0d state=%0d pll_rst=%b fail=%b want 0 1 0", k, state_dbg, pll_rst, fail);
                end
            end
            if (k == 4 || k == 21 || k == 35 || k == 40 || k == 107 || k == 218) begin
                checks++;
                if (state_dbg !== 3'd1 || pll_rst !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_wait k=%0d state=%0d pll_rst=%b want 1 0", k, state_dbg, pll_rst);
                end
            end
            if (k == 108 || k == 110 || k == 219) begin
                checks++;
                if (state_dbg !== 3'd5 || fail !== 1'b1 || pll_rst !== 1'b1 || ch_rst_n !== 3'b000) begin
                    errors++;
                    $display("FAIL timeout_fail k=%0d state=%0d fail=%b pll_rst=%b ch=%b want 5 1 1 000",
                             k, state_dbg, fail, pll_rst, ch_rst_n);
                end
            end
            // Retry in WAIT must be ignored; retry in FAIL restarts.
            retry = (k == 20 || k == 110);
        end
        retry = 1'b0;
    endtask

    task automatic test_loss_run;
        do_reset(1'b1);
        for (int k = 1; k <= 39; k++) begin
            @(negedge refclk);
            if (k == 20) begin
                checks++;
                if (state_dbg !== 3'd4 || ch_rst_n !== 3'b111 || all_ready !== 1'b1 || loss_count !== 2'd0) begin
                    errors++;
                    $display("FAIL loss_before state=%0d ch=%b ar=%b loss=%0d want 4 111 1 0", state_dbg, ch_rst_n, all_ready, loss_count);
                end
            end
            if (k == 21) begin
                checks++;
                if (state_dbg !== 3'd0 || ch_rst_n !== 3'b000 || all_ready !== 1'b0 || loss_count !== 2'd1 || pll_rst !== 1'b1) begin
                    errors++;
                    $display("FAIL loss_edge state=%0d ch=%b ar=%b loss=%0d pll_rst=%b want 0 000 0 1 1",
                             state_dbg, ch_rst_n, all_ready, loss_count, pll_rst);
                end
            end
            if (k == 25 || k == 26) begin
                checks++;
                if (state_dbg !== ((k == 25) ? 3'd1 : 3'd2)) begin
                    errors++;
                    $display("FAIL loss_relock k=%0d state=%0d", k, state_dbg);
                end
            end
            if (k == 34) begin
                checks++;
                if (state_dbg !== 3'd3 || ch_rst_n !== 3'b001) begin
                    errors++;
                    $display("FAIL loss_rerelease state=%0d ch=%b want 3 001", state_dbg, ch_rst_n);
                end
            end
            if (k == 39) begin
                checks++;
                if (state_dbg !== 3'd4 || all_ready !== 1'b1 || loss_count !== 2'd1) begin
                    errors++;
                    $display("FAIL loss_rerun state=%0d ar=%b loss=%0d want 4 1 1", state_dbg, all_ready, loss_count);
                end
            end
            if (k == 18) pll_locked = 1'b0;
            if (k == 21) pll_locked = 1'b1;
        end
    endtask

    task automatic test_saturation;
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset(1'b1);
        repeat (18) @(negedge refclk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (all_ready !== 1'b1) begin
                errors++;
                $display("FAIL sat_run i=%0d ar=%b want 1", i, all_ready);
            end
            pll_locked = 1'b0;
            repeat (2) @(negedge refclk);
            checks++;
            if (all_ready !== 1'b1) begin
                errors++;
                $display("FAIL sat_early i=%0d ar=%b want 1", i, all_ready);
            end
            @(negedge refclk);
            checks++;
            if (loss_count !== sat_exp[i] || all_ready !== 1'b0) begin
                errors++;
                $display("FAIL sat_count i=%0d loss=%0d ar=%b want %0d 0", i, loss_count, all_ready, sat_exp[i]);
            end
            pll_locked = 1'b1;
            repeat (18) @(negedge refclk);
        end
    endtask

    task automatic test_midreset;
        // Continues from RUN with loss_count saturated.
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (15) @(negedge refclk);
        checks++;
        if (state_dbg !== 3'd3 || ch_rst_n !== 3'b011 || loss_count !== 2'd3) begin
            errors++;
            $display("FAIL midrst_pre state=%0d ch=%b loss=%0d want 3 011 3", state_dbg, ch_rst_n, loss_count);
        end
        rst_n = 1'b0;
        @(negedge refclk);
        checks++;
        if (state_dbg !== 3'd0 || ch_rst_n !== 3'b000 || loss_count !== 2'd0 || pll_rst !== 1'b1 ||
            all_ready !== 1'b0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL midrst_post state=%0d ch=%b loss=%0d pll_rst=%b ar=%b fail=%b want 0 000 0 1 0 0",
                     state_dbg, ch_rst_n, loss_count, pll_rst, all_ready, fail);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        retry      = 1'b0;
        test_reset();
        test_clean_lock();
        test_glitch();
        test_timeout();
        test_loss_run();
        test_saturation();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
